sat_arith_pipe: RTL and testbench
=================================

Name: sat_arith_pipe

Overview:
Parametrised, two-stage pipelined signed add/subtract/accumulate unit with overflow detection and a sticky overflow flag. It is the next-generation arithmetic primitive for the Segway control datapath, used for PID term summation and integrator accumulation. Valid/ready handshakes on input and output allow back-pressure from downstream math blocks.

Parameters:
WIDTH, 16, operand/result/accumulator width in bits (two's complement), legal 4..32

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_vld  input  1  operand beat valid
in_rdy  output  1  unit can accept a beat this cycle
op  input  2  00 ADD (A+B), 01 SUB (A-B), 10 ACC (acc+A, B ignored), 11 CLR (acc<=0, result 0)
A  input  WIDTH  signed operand A
B  input  WIDTH  signed operand B
out_vld  output  1  result beat valid
out_rdy  input  1  downstream accepts result
result  output  WIDTH  signed result
ov  output  1  overflow of this result beat
ov_sticky  output  1  OR of all ov since reset or last clear
clr_sticky  input  1  synchronous clear of ov_sticky
acc  output  WIDTH  current accumulator value

Behaviour:
- Reset (async, rst=1): s1_vld=0, out_vld=0, result=0, ov=0, ov_sticky=0, acc=0. Because s1_vld=0 and out_vld=0, in_rdy reads 1 while rst is asserted and immediately after it is released. In-flight beats are discarded when rst is asserted mid-operation.
- Stage 1 (S1): registers op, A and B on each input handshake (in_vld & in_rdy).
- Stage 2 (S2): computes from the S1 registers and the acc register, then registers result and ov.
- Latency is 2 clk from input handshake to out_vld, with no stall. Throughput is 1 beat/clk.
- Pipeline advance:
  - adv2 = s1_vld & (~out_vld | out_rdy)
  - in_rdy = ~s1_vld | adv2 (combinational from out_rdy; no combinational path from in_vld)
  - out_vld clears when out_vld & out_rdy & ~adv2.
- Arithmetic:
  - SUB uses one's complement of B plus carry-in 1.
  - ov = (both adder operands >=0 & sum<0) | (both <0 & sum>=0).
  - SUB of the most negative B is handled by this rule: e.g. 0 - (-2^(W-1)) reports ov=1.
- ACC:
  - sum = acc + A, using the same overflow rule.
  - acc <= result when S2 captures an ACC beat.
  - Back-to-back ACC beats see the updated acc, because acc is read in S2 only; no forwarding hazard.
- CLR: result=0, ov=0, acc<=0 on S2 capture.
- ADD/SUB: acc unchanged.
- ov_sticky:
  - Set in the cycle S2 captures a beat with ov=1.
  - clr_sticky clears it.
  - Simultaneous set and clear: set wins.
- Stall: while out_vld & ~out_rdy, the following hold stable: result, ov, acc, and the S1 registers.

Optional Feature:
Macro SAT_ARITH_SATURATE_EN.
- Defined: on overflow, result clamps to +2^(W-1)-1 if the true sum is positive, or to -2^(W-1) if negative. ACC saturates the stored acc identically. ov is still asserted.
- Undefined: result and acc wrap modulo 2^WIDTH; ov is asserted.

Decomposition:
- Package sat_arith_pkg:
  - op enum constants OP_ADD, OP_SUB, OP_ACC, OP_CLR
  - functions for max_pos(WIDTH) and min_neg(WIDTH)
- Sub-module sat_arith_core: purely combinational, WIDTH-parametrised add/sub with overflow and optional saturation. Instantiated once in S2; the adder's A input is muxed between A and acc.

Test Plan:
All scenarios use WIDTH=16.
- Reset/handshake: rst pulse mid-stream -> out_vld=0, acc=0, ov_sticky=0 immediately; first beat after release ADD 3+4 -> result=7, ov=0, out_vld two clk after the handshake.
- Overflow: ADD 0x7FFF+0x0001 -> wrap build result=0x8000, ov=1; SAT build result=0x7FFF, ov=1; ov_sticky=1 until clr_sticky pulse.
- Subtract edge: SUB 0x0000-0x8000 -> ov=1; SUB 0x8000-0x0001 -> wrap 0x7FFF / SAT 0x8000, ov=1; SUB 5-7 -> 0xFFFE, ov=0.
- Accumulate: CLR, then ACC A=1000 ten times back-to-back -> results 1000..10000, acc=10000; ACC A=0x7000 twice after CLR -> second: wrap 0xE000 / SAT 0x7FFF, ov=1.
- Back-pressure: stream of 6 ADD beats with out_rdy held low 3 clk mid-stream -> in_rdy drops once both stages are full; no beat lost or duplicated; results in order; result stable while stalled.
- Sticky race: clr_sticky asserted in the same clk as an overflowing S2 capture -> ov_sticky remains 1.

Source files
------------

// File: rtl/sat_arith_pkg.sv
// Shared opcode encoding and saturation limits for the saturating arithmetic pipeline.
package sat_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    // Bit patterns in the low `width` bits; callers size-cast to their own width.
    function automatic logic [31:0] max_pos(input int unsigned width);
        return (32'h1 << (width - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] min_neg(input int unsigned width);
        return 32'h1 << (width - 1);
    endfunction

endpackage

// File: rtl/sat_arith_core.sv
// Combinational signed add/sub with overflow detect; clamps on overflow when
// SAT_ARITH_SATURATE_EN is defined, otherwise wraps.
module sat_arith_core
    import sat_arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ov
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] raw;

    always_comb begin
        b_eff = sub ? ~b : b;
        raw   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
        ov    = (~a[WIDTH-1] & ~b_eff[WIDTH-1] &  raw[WIDTH-1]) |
                ( a[WIDTH-1] &  b_eff[WIDTH-1] & ~raw[WIDTH-1]);
    end

`ifdef SAT_ARITH_SATURATE_EN
    localparam logic [WIDTH-1:0] MAXP = WIDTH'(max_pos(WIDTH));
    localparam logic [WIDTH-1:0] MINN = WIDTH'(min_neg(WIDTH));

    // On overflow both operands share a sign, which is the sign of the true sum.
    always_comb begin
        sum = raw;
        if (ov) sum = a[WIDTH-1] ? MINN : MAXP;
    end
`else
    always_comb sum = raw;
`endif

endmodule

// File: rtl/sat_arith_pipe.sv
// Two-stage valid/ready add/sub/accumulate pipeline with sticky overflow.
// Build option: SAT_ARITH_SATURATE_EN selects saturating instead of wrapping results.
module sat_arith_pipe
    import sat_arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] result,
    output logic             ov,
    output logic             ov_sticky,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] acc
);

    logic             s1_vld;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             adv2;
    logic             in_fire;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] core_sum;
    logic             core_ov;
    logic [WIDTH-1:0] s2_result;
    logic             s2_ov;

    always_comb begin
        adv2    = s1_vld & (~out_vld | out_rdy);
        in_rdy  = ~s1_vld | adv2;
        in_fire = in_vld & in_rdy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_op  <= OP_ADD;
            s1_a   <= '0;
            s1_b   <= '0;
        end else if (in_fire) begin
            s1_vld <= 1'b1;
            s1_op  <= op_t'(op);
            s1_a   <= A;
            s1_b   <= B;
        end else if (adv2) begin
            s1_vld <= 1'b0;
        end
    end

    // ACC routes the accumulator into the adder's A side and operand A into its B side.
    always_comb begin
        core_a = (s1_op == OP_ACC) ? acc  : s1_a;
        core_b = (s1_op == OP_ACC) ? s1_a : s1_b;
    end

    sat_arith_core #(.WIDTH(WIDTH)) u_core (
        .a   (core_a),
        .b   (core_b),
        .sub (s1_op == OP_SUB),
        .sum (core_sum),
        .ov  (core_ov)
    );

    always_comb begin
        s2_result = core_sum;
        s2_ov     = core_ov;
        if (s1_op == OP_CLR) begin
            s2_result = '0;
            s2_ov     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            result  <= '0;
            ov      <= 1'b0;
            acc     <= '0;
        end else if (adv2) begin
            out_vld <= 1'b1;
            result  <= s2_result;
            ov      <= s2_ov;
            if (s1_op == OP_ACC || s1_op == OP_CLR) acc <= s2_result;
        end else if (out_vld & out_rdy) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                ov_sticky <= 1'b0;
        else if (adv2 & s2_ov)  ov_sticky <= 1'b1;
        else if (clr_sticky)    ov_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_sat_arith_pipe.sv
// Scoreboard bench for sat_arith_pipe (WIDTH=16); honours SAT_ARITH_SATURATE_EN.
module tb_sat_arith_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic [W-1:0] result;
    logic         ov;
    logic         ov_sticky;
    logic         clr_sticky = 1'b0;
    logic [W-1:0] acc;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [W:0]   sbq[$];
    logic [W-1:0] model_acc = '0;

    sat_arith_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .op         (op),
        .A          (A),
        .B          (B),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .result     (result),
        .ov         (ov),
        .ov_sticky  (ov_sticky),
        .clr_sticky (clr_sticky),
        .acc        (acc)
    );

    always #5 clk = ~clk;

    // Reference model on true integer arithmetic; returns {ov, result}.
    function automatic logic [W:0] model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
        int sa, sb, sacc, t;
        logic o;
        logic [W-1:0] r;
        sa   = int'($signed(ma));
        sb   = int'($signed(mb));
        sacc = int'($signed(model_acc));
        case (mop)
            2'b00:   t = sa + sb;
            2'b01:   t = sa - sb;
            2'b10:   t = sacc + sa;
            default: t = 0;
        endcase
        o = (t > 32767) || (t < -32768);
        r = t[W-1:0];
`ifdef SAT_ARITH_SATURATE_EN
        if (o) r = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        if (mop == 2'b10 || mop == 2'b11) model_acc = r;
        return {o, r};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            logic [W:0] e;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got result=%h ov=%b, required no beat", result, ov);
            end else begin
                e = sbq.pop_front();
                pops++;
                if ({ov, result} !== e) begin
                    errors++;
                    $display("FAIL scoreboard_beat: got result=%h ov=%b, required result=%h ov=%b",
                             result, ov, e[W-1:0], e[W]);
                end
            end
        end
    end

    task automatic send(input logic [1:0] s_op, input logic [W-1:0] s_a, input logic [W-1:0] s_b);
        int n = 0;
        in_vld = 1'b1; op = s_op; A = s_a; B = s_b;
        @(negedge clk);
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_rdy=%b, required 1 within 100 clk", in_rdy);
        end else begin
            sbq.push_back(model(s_op, s_a, s_b));
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sbq.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_vld, result, ov, ov_sticky, acc, in_rdy} !== {1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: out_vld=%b result=%h ov=%b sticky=%b acc=%h in_rdy=%b, required 0 0 0 0 0 1",
                     out_vld, result, ov, ov_sticky, acc, in_rdy);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(2'b11, 16'h0, 16'h0);
        send(2'b10, 16'h7000, 16'h0);
        send(2'b10, 16'h7000, 16'h0);
        send(2'b10, 16'h0001, 16'h0);
        #1;
        checks++;
        if (ov_sticky !== 1'b1) begin
            errors++;
            $display("FAIL reset_precond_sticky: got %b, required 1", ov_sticky);
        end
        rst = 1'b1;
        sbq.delete();
        model_acc = '0;
        #1;
        checks++;
        if ({out_vld, acc, ov_sticky, in_rdy} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_midstream: out_vld=%b acc=%h sticky=%b in_rdy=%b, required 0 0000 0 1",
                     out_vld, acc, ov_sticky, in_rdy);
        end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        in_vld = 1'b1; op = 2'b00; A = 16'd3; B = 16'd4;
        @(negedge clk);
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_rdy: got %b, required 1", in_rdy);
        end
        sbq.push_back(model(2'b00, 16'd3, 16'd4));
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_vld=%b one clk after handshake, required 0", out_vld);
        end
        @(negedge clk);
        checks++;
        if ({out_vld, result, ov} !== {1'b1, 16'd7, 1'b0}) begin
            errors++;
            $display("FAIL latency_first_beat: out_vld=%b result=%h ov=%b, required 1 0007 0", out_vld, result, ov);
        end
        drain();
    endtask

    task automatic test_overflow();
        send(2'b00, 16'h7FFF, 16'h0001);
        drain();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ov_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_hold: got %b, required 1", ov_sticky);
        end
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (ov_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b, required 0", ov_sticky);
        end
    endtask

    task automatic test_sub();
        send(2'b01, 16'h0000, 16'h8000);
        send(2'b01, 16'h8000, 16'h0001);
        send(2'b01, 16'd5, 16'd7);
        send(2'b01, 16'h1234, 16'h0234);
        drain();
        checks++;
        if (acc !== 16'h0) begin
            errors++;
            $display("FAIL sub_acc_unchanged: got acc=%h, required 0000", acc);
        end
    endtask

    task automatic test_accumulate();
        send(2'b11, 16'h0, 16'h0);
        for (int i = 0; i < 10; i++) send(2'b10, 16'd1000, 16'hDEAD);
        drain();
        checks++;
        if (acc !== 16'd10000) begin
            errors++;
            $display("FAIL acc_sum: got acc=%h, required %h", acc, 16'd10000);
        end
        send(2'b11, 16'h0, 16'h0);
        send(2'b10, 16'h7000, 16'h0);
        send(2'b10, 16'h7000, 16'h0);
        drain();
        checks++;
        if (acc !== model_acc) begin
            errors++;
            $display("FAIL acc_overflow: got acc=%h, required %h", acc, model_acc);
        end
        send(2'b11, 16'h0, 16'h0);
        drain();
        checks++;
        if (acc !== 16'h0) begin
            errors++;
            $display("FAIL acc_clr: got acc=%h, required 0000", acc);
        end
    endtask

    task automatic test_back_to_back();
        int pops0 = pops;
        int rdy_low = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(2'b00, 16'(100 * i), 16'(i + 1));
            end
            begin
                logic [W-1:0] held;
                repeat (3) @(posedge clk);
                #1;
                out_rdy = 1'b0;
                @(negedge clk);
                held = result;
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!in_rdy) rdy_low++;
                    checks++;
                    if (out_vld !== 1'b1 || result !== held) begin
                        errors++;
                        $display("FAIL stall_stable: out_vld=%b result=%h, required 1 %h", out_vld, result, held);
                    end
                end
                @(posedge clk); #1;
                out_rdy = 1'b1;
            end
        join
        drain();
        checks++;
        if (rdy_low == 0) begin
            errors++;
            $display("FAIL stall_in_rdy: in_rdy low for %0d clk, required at least 1", rdy_low);
        end
        checks++;
        if (pops - pops0 != 6) begin
            errors++;
            $display("FAIL stall_beat_count: got %0d beats, required 6", pops - pops0);
        end
    endtask

    task automatic test_sticky_race();
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (ov_sticky !== 1'b0) begin
            errors++;
            $display("FAIL race_precond: got %b, required 0", ov_sticky);
        end
        send(2'b00, 16'h8000, 16'hFFFF);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (ov_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_race: got %b, required 1", ov_sticky);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_sub();
        test_accumulate();
        test_back_to_back();
        test_sticky_race();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
